pipeline_hazard_ctrl: RTL and testbench

//  Sequences the 5-stage pipeline. Drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB register enables, flushes and bubbles.

---
 rtl/hazard_pkg.sv | 26 ++
 rtl/hazard_perf_counters.sv | 37 +++
 rtl/pipeline_hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    RUN     = 2'd1,
    MEMWAIT = 2'd2
  } ctrl_state_t;

  // X31 reads as zero, so a load that targets it never produces data a consumer waits on.
  localparam logic [4:0] REG_ZR = 5'd31;

  // A load in EX whose destination is read by the instruction in ID.
  function automatic logic load_use_hit(
    input logic       ex_mem_read,
    input logic [4:0] ex_target,
    input logic       use_rn,
    input logic [4:0] rn,
    input logic       use_rm,
    input logic [4:0] rm
  );
    return ex_mem_read && (ex_target != REG_ZR) &&
           ((use_rn && (rn == ex_target)) || (use_rm && (rm == ex_target)));
  endfunction

endpackage

// File: rtl/hazard_perf_counters.sv
// Three saturating event counters (load-use stalls, branch squashes, memory-wait cycles).
// Only built when HAZARD_PERF_CNT_EN is defined.
`ifdef HAZARD_PERF_CNT_EN
module hazard_perf_counters #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_ldstall_i,
  input  logic             inc_flush_i,
  input  logic             inc_memwait_i,
  output logic [CNT_W-1:0] ldstall_o,
  output logic [CNT_W-1:0] flush_o,
  output logic [CNT_W-1:0] memwait_o
);

  logic [CNT_W-1:0] ldstall_q, flush_q, memwait_q;

  // Count one per active cycle, holding at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ldstall_q <= '0;
      flush_q   <= '0;
      memwait_q <= '0;
    end else begin
      if (inc_ldstall_i && !(&ldstall_q)) ldstall_q <= ldstall_q + CNT_W'(1);
      if (inc_flush_i   && !(&flush_q))   flush_q   <= flush_q + CNT_W'(1);
      if (inc_memwait_i && !(&memwait_q)) memwait_q <= memwait_q + CNT_W'(1);
    end
  end

  assign ldstall_o = ldstall_q;
  assign flush_o   = flush_q;
  assign memwait_o = memwait_q;

endmodule
`endif

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch squash and data-memory wait.
// Control outputs are same-cycle (Mealy) functions of state and inputs.
// Optional HAZARD_PERF_CNT_EN adds perf_ldstall/perf_flush/perf_memwait counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_Rn,
  input  logic [4:0] id_Rm,
  input  logic       id_useRn,
  input  logic       id_useRm,
  input  logic       ex_memRead,
  input  logic [4:0] ex_targetReg,
  input  logic       ex_PCSrc,
  input  logic       mem_access,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       if_id_flush,
  output logic       id_ex_en,
  output logic       id_ex_bubble,
  output logic       ex_mem_en,
  output logic       mem_wb_bubble,
  output logic       mem_timeout,
  output logic [1:0] ctrl_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_ldstall,
  output logic [CNT_W-1:0] perf_flush,
  output logic [CNT_W-1:0] perf_memwait
`endif
);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic             lu_hit_c;
  logic             run_rules_c;

  assign lu_hit_c = load_use_hit(ex_memRead, ex_targetReg, id_useRn, id_Rn, id_useRm, id_Rm);

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= FILL;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Next state and pipeline control; reset forces the flush/bubble pattern.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    run_rules_c   = 1'b0;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_en     = 1'b1;
    mem_wb_bubble = 1'b0;

    case (state_q)
      FILL: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        state_d      = RUN;
      end
      RUN: begin
        if (mem_access && !mem_ready) begin
          wait_cnt_d = CNT_W'(1);
          state_d    = MEMWAIT;
        end else begin
          run_rules_c = 1'b1;
        end
      end
      MEMWAIT: begin
        if (mem_ready || (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1))) begin
          if (!mem_ready) mem_timeout_d = 1'b1;
          wait_cnt_d  = '0;
          state_d     = RUN;
          run_rules_c = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = FILL;
    endcase

    // Freeze the front of the pipe while memory is outstanding.
    if (state_d == MEMWAIT) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end

    // Branch squash outranks a coincident load-use stall.
    if (run_rules_c) begin
      if (ex_PCSrc) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (lu_hit_c) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
      end
    end

    if (!rst) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_en      = 1'b0;
      id_ex_bubble  = 1'b1;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign ctrl_state  = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic inc_ldstall_c, inc_flush_c, inc_memwait_c;

  // Classify this cycle's action from the control pattern it produced.
  assign inc_ldstall_c = rst && !pc_en && !if_id_en && id_ex_en && id_ex_bubble;
  assign inc_flush_c   = rst && if_id_flush && (state_q != FILL);
  assign inc_memwait_c = rst && mem_wb_bubble;

  hazard_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clk           (clk),
    .rst_n         (rst),
    .inc_ldstall_i (inc_ldstall_c),
    .inc_flush_i   (inc_flush_c),
    .inc_memwait_i (inc_memwait_c),
    .ldstall_o     (perf_ldstall),
    .flush_o       (perf_flush),
    .memwait_o     (perf_memwait)
  );
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: the driver queues expected control
// vectors; a monitor on the falling edge pops and compares them.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned MEM_TIMEOUT = 8;
  localparam int unsigned CNT_W       = 16;

  // Vector bit order: pc_en if_id_en if_id_flush id_ex_en id_ex_bubble ex_mem_en mem_wb_bubble mem_timeout state[1:0]
  localparam logic [9:0] E_RST   = 10'b0010101000;
  localparam logic [9:0] E_FILL  = 10'b1010100000;
  localparam logic [9:0] M_FILL  = 10'b1010100111;
  localparam logic [9:0] E_RUN   = 10'b1101010001;
  localparam logic [9:0] E_LU    = 10'b0001110001;
  localparam logic [9:0] E_BR    = 10'b1111110001;
  localparam logic [9:0] E_FRZR  = 10'b0000001001;
  localparam logic [9:0] E_FRZW  = 10'b0000001010;
  localparam logic [9:0] E_RELW  = 10'b1101010010;
  localparam logic [9:0] E_RELBR = 10'b1111110010;
  localparam logic [9:0] T       = 10'b0000000100;
  localparam logic [9:0] ALL     = 10'h3FF;

  typedef struct {
    logic [9:0] v;
    logic [9:0] m;
    string      name;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [4:0] id_Rn, id_Rm, ex_targetReg;
  logic       id_useRn, id_useRm, ex_memRead, ex_PCSrc, mem_access, mem_ready;
  logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en;
  logic       mem_wb_bubble, mem_timeout;
  logic [1:0] ctrl_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] perf_ldstall, perf_flush, perf_memwait;
`endif

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_Rn        (id_Rn),
    .id_Rm        (id_Rm),
    .id_useRn     (id_useRn),
    .id_useRm     (id_useRm),
    .ex_memRead   (ex_memRead),
    .ex_targetReg (ex_targetReg),
    .ex_PCSrc     (ex_PCSrc),
    .mem_access   (mem_access),
    .mem_ready    (mem_ready),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .if_id_flush  (if_id_flush),
    .id_ex_en     (id_ex_en),
    .id_ex_bubble (id_ex_bubble),
    .ex_mem_en    (ex_mem_en),
    .mem_wb_bubble(mem_wb_bubble),
    .mem_timeout  (mem_timeout),
    .ctrl_state   (ctrl_state)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_ldstall (perf_ldstall),
    .perf_flush   (perf_flush),
    .perf_memwait (perf_memwait)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: every cycle with a queued expectation is compared mid-cycle.
  always @(negedge clk) begin
    exp_t       e;
    logic [9:0] act;
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en,
             mem_wb_bubble, mem_timeout, ctrl_state};
      checks++;
      if ((act & e.m) !== (e.v & e.m)) begin
        failures++;
        $display("FAIL %s: got %b expected %b (mask %b)", e.name, act, e.v, e.m);
      end
    end
  end

  // Drive one cycle of inputs just after the rising edge and queue its expectation.
  task automatic cyc(input logic r, input logic [4:0] rn, input logic urn,
                     input logic [4:0] rm, input logic urm, input logic mr,
                     input logic [4:0] tg, input logic br, input logic acc,
                     input logic rdy, input logic [9:0] ev, input logic [9:0] mk,
                     input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_Rn = rn; id_useRn = urn; id_Rm = rm; id_useRm = urm;
    ex_memRead = mr; ex_targetReg = tg; ex_PCSrc = br;
    mem_access = acc; mem_ready = rdy;
    e.v = ev; e.m = mk; e.name = nm;
    q.push_back(e);
  endtask

  task automatic idle(input logic [9:0] ev, input string nm);
    cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ev, ALL, nm);
  endtask

  initial begin
    rst = 1'b0; id_Rn = '0; id_Rm = '0; id_useRn = 1'b0; id_useRm = 1'b0;
    ex_memRead = 1'b0; ex_targetReg = '0; ex_PCSrc = 1'b0;
    mem_access = 1'b0; mem_ready = 1'b0;

    // Reset and fill
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_RST, ALL, "reset0");
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_RST, ALL, "reset1");
    cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_FILL, M_FILL, "fill");
    idle(E_RUN, "run_after_fill");

    // Load-use
    cyc(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, E_LU, ALL, "lu_rn");
    cyc(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_RUN, ALL, "lu_after");
    cyc(1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, E_LU, ALL, "lu_rm");
    cyc(1'b1, 5'd7, 1'b0, 5'd1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, E_RUN, ALL, "lu_rn_unused");
    cyc(1'b1, 5'd31, 1'b1, 5'd31, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, E_RUN, ALL, "lu_xzr");
    cyc(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, E_RUN, ALL, "no_load");

    // Branch over load-use
    cyc(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, E_BR, ALL, "br_over_lu");
    idle(E_RUN, "run_after_br");

    // Memory access with no ready is ignored when no access is in MEM
    cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_RUN, ALL, "noacc");

    // Five-cycle memory wait, then release
    cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, E_FRZR, ALL, "mw_enter");
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, E_FRZW, ALL, "mw_hold");
    cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, E_RELW, ALL, "mw_release");
    idle(E_RUN, "run_after_mw");

    // Memory wait outranks a branch; the held branch is serviced on release
    cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, E_FRZR, ALL, "mw_over_br");
    cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, E_RELBR, ALL, "mw_release_br");
    idle(E_RUN, "run_after_relbr");

    // Timeout: entry cycle plus six waits, forced release at count 7
    cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, E_FRZR, ALL, "to_enter");
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, E_FRZW, ALL, "to_hold");
    cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, E_RELW, ALL, "to_release");
    idle(E_RUN | T, "to_sticky0");
    idle(E_RUN | T, "to_sticky1");

    // Reset in the middle of a memory wait
    cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, E_FRZR | T, ALL, "rmw_enter");
    cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, E_FRZW | T, ALL, "rmw_hold");
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, E_RST, ALL, "rmw_reset");
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if ((perf_ldstall !== '0) || (perf_flush !== '0) || (perf_memwait !== '0)) begin
      failures++;
      $display("FAIL perf_reset: got %0d/%0d/%0d expected 0/0/0",
               perf_ldstall, perf_flush, perf_memwait);
    end
`endif
    cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_FILL, M_FILL, "rmw_fill");
    idle(E_RUN, "rmw_run");

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
